// File: rtl/ttl74_pkg.sv
// Shared constants for the 74151 scanner: FSM encoding and selector geometry.
package ttl74_pkg;
  localparam int MUX_CHANNELS  = 8;
  localparam int MUX_SEL_WIDTH = 3;

  localparam logic [1:0] SCAN_IDLE   = 2'd0;
  localparam logic [1:0] SCAN_SETTLE = 2'd1;
  localparam logic [1:0] SCAN_SAMPLE = 2'd2;
endpackage

// File: rtl/ttl74151_scanner_settle_timer.sv
// Settle-time counter for one selector channel; runs only while enabled, cleared otherwise.
module scan_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);
  localparam logic [3:0] TARGET = 4'(SETTLE_CYCLES);

  logic [3:0] r_count;
  logic [3:0] w_count_inc;

  assign w_count_inc = r_count + 4'd1;
  // done flags the edge at which the count reaches SETTLE_CYCLES
  assign o_done = i_enable && (w_count_inc == TARGET);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= 4'd0;
    end else if (i_enable) begin
      r_count <= w_count_inc;
    end
  end
endmodule

// File: rtl/ttl74151_scanner.sv
// Serial reader for an external 8:1 selector: steps the address, waits, samples,
// and presents the assembled byte with a one-cycle valid strobe.
module ttl74151_scanner
  import ttl74_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_mux_out,
  output logic [MUX_SEL_WIDTH-1:0] o_mux_sel,
  output logic                     o_mux_enable_n,
  output logic [MUX_CHANNELS-1:0]  o_data,
  output logic                     o_valid,
  output logic                     o_busy
);
  localparam logic [1:0] FIRST_PHASE = (SETTLE_CYCLES == 0) ? SCAN_SAMPLE : SCAN_SETTLE;
  localparam logic [MUX_SEL_WIDTH-1:0] LAST_CHAN = MUX_SEL_WIDTH'(MUX_CHANNELS - 1);

  logic [1:0]               r_state;
  logic [MUX_SEL_WIDTH-1:0] r_chan;
  logic                     r_enable_n;
  logic [MUX_CHANNELS-1:0]  r_shadow;
  logic [MUX_CHANNELS-1:0]  r_data;
  logic                     r_valid;
  logic                     r_busy;
  logic                     w_in_settle;
  logic                     w_settle_done;

  assign w_in_settle = (r_state == SCAN_SETTLE);

  scan_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (!w_in_settle),
    .i_enable(w_in_settle),
    .o_done  (w_settle_done)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= SCAN_IDLE;
      r_chan     <= '0;
      r_enable_n <= 1'b1;
      r_shadow   <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        SCAN_IDLE: begin
          if (i_start && !i_abort) begin
            r_state    <= FIRST_PHASE;
            r_chan     <= '0;
            r_enable_n <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        SCAN_SETTLE: begin
          if (i_abort) begin
            r_state    <= SCAN_IDLE;
            r_chan     <= '0;
            r_enable_n <= 1'b1;
            r_busy     <= 1'b0;
          end else if (w_settle_done) begin
            r_state <= SCAN_SAMPLE;
          end
        end
        SCAN_SAMPLE: begin
          if (i_abort) begin
            r_state    <= SCAN_IDLE;
            r_chan     <= '0;
            r_enable_n <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_shadow[r_chan] <= i_mux_out;
            if (r_chan == LAST_CHAN) begin
              // last bit bypasses the shadow so data lands together with valid
              r_data     <= {i_mux_out, r_shadow[MUX_CHANNELS-2:0]};
              r_valid    <= 1'b1;
              r_state    <= SCAN_IDLE;
              r_chan     <= '0;
              r_enable_n <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_chan  <= r_chan + 1'b1;
              r_state <= FIRST_PHASE;
            end
          end
        end
        default: begin
          r_state    <= SCAN_IDLE;
          r_chan     <= '0;
          r_enable_n <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_mux_sel      = r_chan;
  assign o_mux_enable_n = r_enable_n;
  assign o_data         = r_data;
  assign o_valid        = r_valid;
  assign o_busy         = r_busy;
endmodule

// File: tb/tb_ttl74151_scanner.sv
// Bench for ttl74151_scanner: two instances (settle 1 and 0) against a cycle-count model.
module tb_ttl74151_scanner;
  localparam int S0 = 1;
  localparam int S1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2];
  logic       st[2];
  logic       ab[2];
  logic       mo[2];
  logic [2:0] sel[2];
  logic       en_n[2];
  logic [7:0] dat[2];
  logic       vld[2];
  logic       bsy[2];
  logic [7:0] pat[2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int vq0[$];
  int vq1[$];

  // model state: active flag and edges elapsed since the accepted start
  bit         m_act[2] = '{0, 0};
  int         m_t[2] = '{0, 0};
  logic [7:0] m_sh[2] = '{8'h00, 8'h00};
  logic [7:0] m_dat[2] = '{8'h00, 8'h00};
  bit         m_vld[2] = '{0, 0};

  ttl74151_scanner #(.SETTLE_CYCLES(S0)) u_s1 (
    .i_clock(clk), .i_reset(rst[0]), .i_start(st[0]), .i_abort(ab[0]), .i_mux_out(mo[0]),
    .o_mux_sel(sel[0]), .o_mux_enable_n(en_n[0]), .o_data(dat[0]), .o_valid(vld[0]), .o_busy(bsy[0])
  );

  ttl74151_scanner #(.SETTLE_CYCLES(S1)) u_s0 (
    .i_clock(clk), .i_reset(rst[1]), .i_start(st[1]), .i_abort(ab[1]), .i_mux_out(mo[1]),
    .o_mux_sel(sel[1]), .o_mux_enable_n(en_n[1]), .o_data(dat[1]), .o_valid(vld[1]), .o_busy(bsy[1])
  );

  // external selector: disabled output reads low
  assign mo[0] = en_n[0] ? 1'b0 : pat[0][sel[0]];
  assign mo[1] = en_n[1] ? 1'b0 : pat[1][sel[1]];

  function automatic int sc(input int d);
    return (d == 0) ? S0 : S1;
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d at cycle %0d", nm, d, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int p;
      int k;
      bit was;
      p   = sc(d) + 1;
      was = m_act[d];
      if (rst[d]) begin
        m_act[d] = 0; m_t[d] = 0; m_sh[d] = 8'h00; m_dat[d] = 8'h00; m_vld[d] = 0;
      end else begin
        m_vld[d] = 0;
        if (was) begin
          if (ab[d]) begin
            m_act[d] = 0;
          end else if ((m_t[d] + 1) % p == 0) begin
            k = (m_t[d] + 1) / p - 1;
            m_sh[d][k] = pat[d][k];
            if (k == 7) begin
              m_dat[d] = m_sh[d];
              m_vld[d] = 1;
              m_act[d] = 0;
            end else begin
              m_t[d]++;
            end
          end else begin
            m_t[d]++;
          end
        end else if (st[d] && !ab[d]) begin
          m_act[d] = 1;
          m_t[d] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        int esel;
        esel = m_act[d] ? (m_t[d] / (sc(d) + 1)) : 0;
        chk("sel", d, int'(sel[d]), esel);
        chk("enable_n", d, int'(en_n[d]), m_act[d] ? 0 : 1);
        chk("busy", d, int'(bsy[d]), int'(m_act[d]));
        chk("valid", d, int'(vld[d]), int'(m_vld[d]));
        chk("data", d, int'(dat[d]), int'(m_dat[d]));
        if (vld[d]) begin
          if (d == 0) vq0.push_back(cyc);
          else vq1.push_back(cyc);
        end
      end
    end
  end

  task automatic pulse_start(input int d);
    @(negedge clk);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  task automatic wait_sel(input int d, input int v, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (int'(sel[d]) == v) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int e0;
    bit ok;
    rst = '{1'b1, 1'b1};
    st  = '{1'b0, 1'b0};
    ab  = '{1'b0, 1'b0};
    pat = '{8'h00, 8'h00};
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_sel", d, int'(sel[d]), 0);
      chk("reset_enable_n", d, int'(en_n[d]), 1);
      chk("reset_data", d, int'(dat[d]), 0);
      chk("reset_valid", d, int'(vld[d]), 0);
      chk("reset_busy", d, int'(bsy[d]), 0);
    end
    chk_on = 1'b1;
    rst = '{1'b0, 1'b0};
    repeat (20) @(negedge clk);
    chk("idle_valids", 0, vq0.size(), 0);
    chk("idle_valids", 1, vq1.size(), 0);
    chk("idle_enable_n", 0, int'(en_n[0]), 1);

    // basic scan, settle 1
    pat[0] = 8'hA5;
    vq0.delete();
    pulse_start(0);
    e0 = cyc;
    repeat (20) @(negedge clk);
    chk("basic_valid_count", 0, vq0.size(), 1);
    if (vq0.size() > 0) chk("basic_latency", 0, vq0[0] - e0, 16);
    chk("basic_data", 0, int'(dat[0]), 'hA5);
    chk("model_basic_data", 0, int'(m_dat[0]), 'hA5);

    // zero settle, start held 30 cycles
    pat[1] = 8'h3C;
    vq1.delete();
    @(negedge clk);
    st[1] = 1'b1;
    @(negedge clk);
    e0 = cyc;
    repeat (29) @(negedge clk);
    st[1] = 1'b0;
    repeat (12) @(negedge clk);
    chk("zero_valid_count", 1, vq1.size(), 4);
    for (int i = 0; i < 3; i++) begin
      if (vq1.size() > i) chk("zero_valid_cycle", 1, vq1[i] - e0, 8 + 9 * i);
    end
    chk("zero_data", 1, int'(dat[1]), 'h3C);

    // abort mid-scan
    pat[0] = 8'hFF;
    pulse_start(0);
    repeat (20) @(negedge clk);
    chk("abort_pre_data", 0, int'(dat[0]), 'hFF);
    pat[0] = 8'h00;
    vq0.delete();
    pulse_start(0);
    wait_sel(0, 4, ok);
    chk("abort_reach_sel4", 0, int'(ok), 1);
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    chk("abort_enable_n", 0, int'(en_n[0]), 1);
    chk("abort_busy", 0, int'(bsy[0]), 0);
    chk("abort_sel", 0, int'(sel[0]), 0);
    repeat (20) @(negedge clk);
    chk("abort_valids", 0, vq0.size(), 0);
    chk("abort_data", 0, int'(dat[0]), 'hFF);
    pat[0] = 8'h5A;
    pulse_start(0);
    repeat (20) @(negedge clk);
    chk("after_abort_count", 0, vq0.size(), 1);
    chk("after_abort_data", 0, int'(dat[0]), 'h5A);

    // reset mid-scan
    vq0.delete();
    pulse_start(0);
    wait_sel(0, 3, ok);
    chk("reset_reach_sel3", 0, int'(ok), 1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("midreset_data", 0, int'(dat[0]), 0);
    chk("midreset_enable_n", 0, int'(en_n[0]), 1);
    chk("midreset_sel", 0, int'(sel[0]), 0);
    chk("midreset_busy", 0, int'(bsy[0]), 0);
    repeat (20) @(negedge clk);
    chk("midreset_valids", 0, vq0.size(), 0);

    // start while busy is ignored
    pat[0] = 8'h96;
    vq0.delete();
    pulse_start(0);
    repeat (4) @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("busy_start_count", 0, vq0.size(), 1);
    chk("busy_start_data", 0, int'(dat[0]), 'h96);

    // start and abort together in idle
    vq0.delete();
    st[0] = 1'b1;
    ab[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    ab[0] = 1'b0;
    chk("start_abort_busy", 0, int'(bsy[0]), 0);
    repeat (20) @(negedge clk);
    chk("start_abort_valids", 0, vq0.size(), 0);

    // abort on the channel-7 sample edge (settle 0: sel==7 is the sample cycle)
    pat[1] = 8'hC3;
    vq1.delete();
    pulse_start(1);
    wait_sel(1, 7, ok);
    chk("ch7_reach", 1, int'(ok), 1);
    ab[1] = 1'b1;
    @(negedge clk);
    ab[1] = 1'b0;
    chk("ch7_abort_busy", 1, int'(bsy[1]), 0);
    repeat (5) @(negedge clk);
    chk("ch7_abort_valids", 1, vq1.size(), 0);
    chk("ch7_abort_data", 1, int'(dat[1]), 'h3C);

    // randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rst[d] = ($urandom_range(0, 299) == 0);
        st[d]  = ($urandom_range(0, 3) == 0);
        ab[d]  = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 7) == 0) pat[d] = 8'($urandom);
      end
    end
    rst = '{1'b0, 1'b0};
    st  = '{1'b0, 1'b0};
    ab  = '{1'b0, 1'b0};
    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
